shift_right_serial: RTL and testbench

- Multicycle right shifter/rotator for the execute stage.
- Handles rotate-right, logical shift-right and arithmetic shift-right of a 16-bit operand.
- Shifts one bit position per cycle under a start/busy/done handshake.
- Complements the single-cycle left barrel shifter, giving the ALU a low-area right-shift path for SRL/SRA/ROR instructions.

---
 rtl/shift_right_serial_pkg.sv | 31 +++
 rtl/shift_right_serial_if.sv | 27 ++
 rtl/shift_right_serial_step.sv | 28 ++
 rtl/shift_right_serial.sv | 88 ++++++++
 tb/tb_shift_right_serial.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/shift_right_serial_pkg.sv
// Shared encodings and defaults for the serial right shifter/rotator.
// Also holds the fill-bit rule so every right-shift datapath agrees on it.
package shift_right_serial_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CW    = 4;

    localparam logic [1:0] OP_ROR = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        FIN   = 2'b10
    } state_e;

    // Bit entering at the MSB on a one-position right step; 2'b11 behaves as SRL.
    function automatic logic select_fill(input logic [1:0] op,
                                         input logic       msb,
                                         input logic       lsb);
        logic fill;
        case (op)
            OP_ROR:  fill = lsb;
            OP_SRA:  fill = msb;
            default: fill = 1'b0;
        endcase
        return fill;
    endfunction

endpackage

// File: rtl/shift_right_serial_if.sv
// Request/response bundle between the ALU sequencer and the serial right shifter.
interface shift_right_serial_if
    import shift_right_serial_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CW    = DEF_CW
) ();

    logic             start;
    logic [WIDTH-1:0] in;
    logic [1:0]       opsel;
    logic [CW-1:0]    count;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;

    modport master (
        output start, in, opsel, count,
        input  busy, done, out
    );

    modport slave (
        input  start, in, opsel, count,
        output busy, done, out
    );

endinterface

// File: rtl/shift_right_serial_step.sv
// One-position right step (rotate, logical or arithmetic) of a WIDTH-bit operand.
// Purely combinational so a future barrel shifter can chain several of these.
module shift_right_step
    import shift_right_serial_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] opnd,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] res
);

    logic fill;

    always_comb begin
        fill = select_fill(op, opnd[WIDTH-1], opnd[0]);
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_bit
            assign res[gi] = opnd[gi+1];
        end
    endgenerate

    assign res[WIDTH-1] = fill;

endmodule

// File: rtl/shift_right_serial.sv
// Multicycle right shifter/rotator: one bit per cycle under start/busy/done.
// Operands are captured on an accepted start; out only changes when done rises.
module shift_right_serial
    import shift_right_serial_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CW    = DEF_CW
) (
    input  logic                 clk,
    input  logic                 rst,
    shift_right_serial_if.slave  bus
);

    state_e           state_reg, state_next;
    logic [WIDTH-1:0] work_reg,  work_next;
    logic [CW-1:0]    rem_reg,   rem_next;
    logic [1:0]       op_reg,    op_next;
    logic [WIDTH-1:0] out_reg,   out_next;
    logic             done_reg,  done_next;
    logic [WIDTH-1:0] step_res;

    shift_right_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .opnd (work_reg),
        .op   (op_reg),
        .res  (step_res)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            work_reg  <= '0;
            rem_reg   <= '0;
            op_reg    <= '0;
            out_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            work_reg  <= work_next;
            rem_reg   <= rem_next;
            op_reg    <= op_next;
            out_reg   <= out_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        work_next  = work_reg;
        rem_next   = rem_reg;
        op_next    = op_reg;
        out_next   = out_reg;
        done_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    work_next  = bus.in;
                    op_next    = bus.opsel;
                    rem_next   = bus.count;
                    state_next = (bus.count != '0) ? SHIFT : FIN;
                end
            end
            SHIFT: begin
                work_next = step_res;
                rem_next  = rem_reg - CW'(1);
                if (rem_reg == CW'(1)) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                // done is registered so it rises on the same edge as out.
                out_next   = work_reg;
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.busy = (state_reg != IDLE);
    assign bus.done = done_reg;
    assign bus.out  = out_reg;

endmodule

// File: tb/tb_shift_right_serial.sv
// Directed bench for shift_right_serial: scoreboard of expected results, checked on done.
module tb_shift_right_serial;
    import shift_right_serial_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    shift_right_serial_if #(.WIDTH(16), .CW(4)) bus ();

    shift_right_serial #(.WIDTH(16), .CW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int compared = 0;
    int mismatched = 0;
    logic [15:0] exp_q[$];
    logic [15:0] last_out = 16'h0000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] model(input logic [15:0] v, input logic [1:0] op,
                                          input logic [3:0] cnt);
        logic [15:0] r;
        logic f;
        r = v;
        for (int i = 0; i < int'(cnt); i++) begin
            if (op == 2'b00)      f = r[0];
            else if (op == 2'b10) f = r[15];
            else                  f = 1'b0;
            r = {f, r[15:1]};
        end
        return r;
    endfunction

    // Issues one operation; disturb>0 pulses a rogue start that many cycles after acceptance.
    task automatic run_op(input string name, input logic [15:0] din, input logic [1:0] op,
                          input logic [3:0] cnt, input int disturb);
        int k;
        int busy_cnt;
        int lat;
        logic [15:0] expv;
        @(negedge clk);
        bus.in    = din;
        bus.opsel = op;
        bus.count = cnt;
        bus.start = 1'b1;
        exp_q.push_back(model(din, op, cnt));
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.in    = ~din;
        bus.count = ~cnt;
        check({name, "_out_hold_on_start"}, 32'(bus.out), 32'(last_out));
        busy_cnt = 0;
        lat = -1;
        k = 0;
        while (k < 40 && lat < 0) begin
            if (bus.busy) busy_cnt++;
            if (disturb > 0 && k == disturb) begin
                bus.start = 1'b1;
                bus.in    = 16'hFFFF;
                bus.opsel = OP_SRA;
                bus.count = 4'd0;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            k++;
            if (bus.done) lat = k;
        end
        bus.start = 1'b0;
        if (lat < 0) begin
            check({name, "_done_timeout"}, 32'(lat), 32'(cnt) + 1);
        end else begin
            check({name, "_latency"}, 32'(lat), 32'(cnt) + 1);
            check({name, "_busy_cycles"}, 32'(busy_cnt), 32'(cnt) + 1);
            if (exp_q.size() == 0) begin
                check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd1);
            end else begin
                expv = exp_q.pop_front();
                check({name, "_out"}, 32'(bus.out), 32'(expv));
                last_out = expv;
            end
            @(posedge clk); #1;
            check({name, "_done_pulse"}, 32'(bus.done), 32'd0);
        end
        $display("op %s: in=%h opsel=%b count=%0d out=%h latency=%0d busy=%0d",
                 name, din, op, cnt, bus.out, lat, busy_cnt);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.in    = '0;
        bus.opsel = '0;
        bus.count = '0;
        #12;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_out",  32'(bus.out),  32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("ror_8001_4",  16'h8001, OP_ROR, 4'd4, 0);
        check("ror_const", 32'(bus.out), 32'h1800);
        run_op("srl_8000_15", 16'h8000, OP_SRL, 4'd15, 0);
        check("srl_const", 32'(bus.out), 32'h0001);
        run_op("sra_8000_15", 16'h8000, OP_SRA, 4'd15, 0);
        check("sra_neg_const", 32'(bus.out), 32'hFFFF);
        run_op("sra_4000_2",  16'h4000, OP_SRA, 4'd2, 0);
        check("sra_pos_const", 32'(bus.out), 32'h1000);
        run_op("sra_beef_0",  16'hBEEF, OP_SRA, 4'd0, 0);
        check("zero_cnt_const", 32'(bus.out), 32'hBEEF);
        run_op("op11_f00f_4", 16'hF00F, 2'b11, 4'd4, 0);
        check("op11_const", 32'(bus.out), 32'h0F00);
        run_op("busy_prot",   16'h00F0, OP_SRL, 4'd4, 2);
        check("busy_prot_const", 32'(bus.out), 32'h000F);
        // After the protected op, the unit must be idle: the rogue start was dropped.
        check("busy_prot_idle", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            run_op("rand", 16'($urandom), 2'($urandom_range(0, 3)),
                   4'($urandom_range(0, 15)), 0);
        end

        // Reset in the middle of a long operation.
        @(negedge clk);
        bus.in = 16'h1234; bus.opsel = OP_ROR; bus.count = 4'd8; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_out",  32'(bus.out),  32'd0);
        $display("op midrst: async reset during shift, out=%h busy=%b", bus.out, bus.busy);
        @(negedge clk);
        rst = 1'b0;
        last_out = 16'h0000;
        run_op("after_rst",   16'h0002, OP_ROR, 4'd1, 0);
        check("after_rst_const", 32'(bus.out), 32'h0001);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
